// File: rtl/branch_predictor.sv
// Fetch-side next-PC predictor: direct-mapped BTB with 2-bit saturating counters,
// trained from EX-stage branch resolution, with mispredict detection and redirect.
module branch_predictor #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_branch,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int TAG_W   = 32 - IDX_W;
  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Fetch-side lookup reads pre-edge contents, so a same-cycle update is not bypassed.
  logic [IDX_W-1:0] f_idx;
  logic             f_hit;

  assign f_idx       = if_pc[IDX_W-1:0];
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == if_pc[31:IDX_W]);
  assign pred_taken  = !rst && f_hit && ctr_q[f_idx][1];
  assign pred_target = pred_taken ? target_q[f_idx] : if_pc + 32'd1;

  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;

  assign u_idx = upd_pc[IDX_W-1:0];
  assign u_tag = upd_pc[31:IDX_W];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // A non-branch that was predicted taken is an alias false hit and must be redirected.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = (upd_is_branch && upd_taken) ? upd_target : upd_pc + 32'd1;
    if (upd_valid && !rst) begin
      if (upd_is_branch)
        mispredict = (upd_pred_taken != upd_taken) ||
                     (upd_taken && (upd_pred_target != upd_target));
      else
        mispredict = upd_pred_taken;
    end
  end

  // NOTE: only valid/ctr need reset; tag/target are don't-care while invalid, so
  // they live in a reset-free block and can map onto plain storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (upd_valid) begin
      if (upd_is_branch) begin
        if (u_hit) begin
          ctr_q[u_idx] <= upd_taken ? sat_inc(ctr_q[u_idx]) : sat_dec(ctr_q[u_idx]);
        end else if (upd_taken) begin
          valid_q[u_idx] <= 1'b1;
          ctr_q[u_idx]   <= 2'b10;
        end
      end else if (upd_pred_taken && u_hit) begin
        valid_q[u_idx] <= 1'b0;
      end
    end
  end

  // On a hit the tag already matches, so tag and target are written for any taken branch.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_is_branch && upd_taken) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (upd_valid && upd_is_branch) branch_cnt <= branch_cnt + 32'd1;
      if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule
